// File: rtl/uart_pkg.sv
// Shared UART definitions: launch FSM encoding and the default transmit FIFO depth.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  typedef enum bit [1:0] {
    LS_IDLE        = 2'd0,
    LS_LAUNCH      = 2'd1,
    LS_WAIT_ACTIVE = 2'd2,
    LS_WAIT_DONE   = 2'd3
  } launch_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a registered fill count as the single source of full/empty,
// plus a sticky overflow flag for writes attempted while full.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH  = UART_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  input  logic [7:0]       i_push_byte,
  input  logic             i_pop,
  output logic [7:0]       o_head_byte,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ready,
  output logic             o_overflow
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok;
  logic              pop_ok;

  // Ready is registered, so a same-cycle pop cannot rescue a write into a full FIFO.
  assign push_ok = i_push_valid && !full_q;
  assign pop_ok  = i_pop && !empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    if (i_push_valid && full_q) begin
      overflow_d = 1'b1;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_push_byte;
    end
  end

  assign o_head_byte = mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_ready     = !full_q;
  assign o_overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit front end: buffers host bytes and launches one byte at a time,
// only once the transmitter reports neither active nor done.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = UART_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Wr_Valid,
  input  logic [7:0]       i_Wr_Byte,
  output logic             o_Wr_Ready,
  output logic             o_TX_Data_Valid,
  output logic [7:0]       o_TX_Byte,
  input  logic             i_TX_Active,
  input  logic             i_TX_Done,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Empty,
  output logic             o_Full,
  output logic             o_Overflow
);

  launch_state_e state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    head_byte;
  logic          pop;
  logic          fifo_empty;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (i_Wr_Valid),
    .i_push_byte  (i_Wr_Byte),
    .i_pop        (pop),
    .o_head_byte  (head_byte),
    .o_count      (o_Count),
    .o_empty      (fifo_empty),
    .o_full       (o_Full),
    .o_ready      (o_Wr_Ready),
    .o_overflow   (o_Overflow)
  );

  // Done is checked as well as Active: Done outlasts Active by two cycles, and
  // after a reset a frame from before may still be finishing on the line.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      LS_IDLE: begin
        if (!fifo_empty && !i_TX_Active && !i_TX_Done) begin
          tx_byte_d = head_byte;
          pop       = 1'b1;
          state_d   = LS_LAUNCH;
        end
      end
      LS_LAUNCH: begin
        state_d = LS_WAIT_ACTIVE;
      end
      LS_WAIT_ACTIVE: begin
        if (i_TX_Active) begin
          state_d = LS_WAIT_DONE;
        end
      end
      LS_WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = LS_IDLE;
        end
      end
      default: begin
        state_d = LS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LS_IDLE;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign o_TX_Data_Valid = (state_q == LS_LAUNCH);
  assign o_TX_Byte       = tx_byte_q;
  assign o_Empty         = fifo_empty;

endmodule
